bsg_dmc_ui_mport: RTL and testbench

- Multi-port front end for the DMC user interface; successor to the single-client app_* attachment.
- Arbitrates num_ports_p clients round-robin onto one app_* command and write-data channel.
- Tracks outstanding reads in a port-ID FIFO and steers returning read bursts to the issuing port.
- Sits in the ui_clk_i domain between the client fabric and the controller's app_* ports.

---
 rtl/bsg_dmc_ui_mport.sv | 195 +++++++++++++++++++
 tb/tb_bsg_dmc_ui_mport.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_dmc_ui_mport.sv
// Multi-port round-robin front end onto the DMC app_* command / write-data / read-return channels.
// Latency: grant (port_ready_o) in the IDLE cycle a port is eligible, app_en_o the cycle after; read steering is combinational.
// Backpressure: app_rdy_i holds the command, app_wdf_rdy_i stalls write beats, reads are refused while the outstanding FIFO is full.
//
// Ports: ui_clk_i/ui_reset_n_i (async active-low assert; deassertion expected synchronous to ui_clk_i),
// per-port command (port_v_i/cmd/addr -> port_ready_o), per-port write beats (port_wdata_* -> port_wdata_ready_o),
// one-hot read steering (port_rdata_v_o + broadcast data/last), app_* controller side, occupancy and sticky error.
module bsg_dmc_ui_mport #(
    parameter int num_ports_p     = 4,
    parameter int ui_addr_width_p = 28,
    parameter int ui_data_width_p = 64,
    parameter int burst_len_p     = 2,
    parameter int rd_fifo_depth_p = 8
) (
    input  logic                                          ui_clk_i,
    input  logic                                          ui_reset_n_i,
    input  logic [num_ports_p-1:0]                        port_v_i,
    input  logic [3*num_ports_p-1:0]                      port_cmd_i,
    input  logic [ui_addr_width_p*num_ports_p-1:0]        port_addr_i,
    output logic [num_ports_p-1:0]                        port_ready_o,
    input  logic [num_ports_p-1:0]                        port_wdata_v_i,
    input  logic [ui_data_width_p*num_ports_p-1:0]        port_wdata_i,
    input  logic [(ui_data_width_p>>3)*num_ports_p-1:0]   port_wmask_i,
    output logic [num_ports_p-1:0]                        port_wdata_ready_o,
    output logic [num_ports_p-1:0]                        port_rdata_v_o,
    output logic [ui_data_width_p-1:0]                    port_rdata_o,
    output logic                                          port_rdata_last_o,
    output logic                                          app_en_o,
    output logic [2:0]                                    app_cmd_o,
    output logic [ui_addr_width_p-1:0]                    app_addr_o,
    input  logic                                          app_rdy_i,
    output logic                                          app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]                    app_wdf_data_o,
    output logic [(ui_data_width_p>>3)-1:0]               app_wdf_mask_o,
    output logic                                          app_wdf_end_o,
    input  logic                                          app_wdf_rdy_i,
    input  logic                                          app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]                    app_rd_data_i,
    input  logic                                          app_rd_data_end_i,
    output logic [$clog2(rd_fifo_depth_p+1)-1:0]          rd_outstanding_o,
    output logic                                          rd_err_o
);

    localparam int mask_w = ui_data_width_p >> 3;
    localparam int pid_w  = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;
    localparam int cnt_w  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam int ptr_w  = (rd_fifo_depth_p > 1) ? $clog2(rd_fifo_depth_p) : 1;
    localparam int occ_w  = $clog2(rd_fifo_depth_p + 1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA} state_e;

    state_e                     state_q, state_d;
    logic [pid_w-1:0]           rr_q, gnt_q, gnt_idx;
    logic                       wr_q;
    logic [ui_addr_width_p-1:0] addr_q;
    logic [cnt_w-1:0]           beat_q;
    logic [pid_w-1:0]           fifo_mem [rd_fifo_depth_p];
    logic [ptr_w-1:0]           rd_ptr_q, wr_ptr_q;
    logic [occ_w-1:0]           count_q;
    logic                       rd_err_q;

    logic [num_ports_p-1:0]     elig;
    logic                       found, grant, push, pop, beat_acc, beat_last;
    logic                       fifo_full, fifo_empty;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(rd_fifo_depth_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign fifo_full  = (count_q == occ_w'(rd_fifo_depth_p));
    assign fifo_empty = (count_q == '0);
    assign beat_last  = (beat_q == cnt_w'(burst_len_p - 1));

    // Any encoding other than WRITE (0) is a read and needs a free FIFO slot.
    always_comb begin
        elig = '0;
        for (int k = 0; k < num_ports_p; k++) begin
            elig[k] = port_v_i[k] && ((port_cmd_i[3*k +: 3] == 3'd0) || !fifo_full);
        end
    end

    // First eligible port at or after the round-robin pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < num_ports_p; i++) begin
            if (!found && elig[(int'(rr_q) + i) % num_ports_p]) begin
                found   = 1'b1;
                gnt_idx = pid_w'((int'(rr_q) + i) % num_ports_p);
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        grant              = 1'b0;
        push               = 1'b0;
        beat_acc           = 1'b0;
        port_ready_o       = '0;
        port_wdata_ready_o = '0;
        app_en_o           = 1'b0;
        app_wdf_wren_o     = 1'b0;
        app_wdf_data_o     = '0;
        app_wdf_mask_o     = '0;
        app_wdf_end_o      = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so the combinational ready is quiet while held in reset.
                if (found && ui_reset_n_i) begin
                    grant                 = 1'b1;
                    port_ready_o[gnt_idx] = 1'b1;
                    state_d               = CMD;
                end
            end
            CMD: begin
                app_en_o = 1'b1;
                if (app_rdy_i) begin
                    if (wr_q) begin
                        state_d = WDATA;
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WDATA: begin
                app_wdf_wren_o            = port_wdata_v_i[gnt_q];
                app_wdf_data_o            = port_wdata_i[gnt_q*ui_data_width_p +: ui_data_width_p];
                app_wdf_mask_o            = port_wmask_i[gnt_q*mask_w +: mask_w];
                app_wdf_end_o             = beat_last;
                port_wdata_ready_o[gnt_q] = app_wdf_rdy_i;
                beat_acc                  = port_wdata_v_i[gnt_q] && app_wdf_rdy_i;
                if (beat_acc && beat_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read return: head of the FIFO owns every beat; a beat with nothing outstanding is dropped.
    assign pop = app_rd_data_valid_i && app_rd_data_end_i && !fifo_empty;

    always_comb begin
        port_rdata_v_o = '0;
        if (app_rd_data_valid_i && !fifo_empty) port_rdata_v_o[fifo_mem[rd_ptr_q]] = 1'b1;
    end

    assign port_rdata_o      = ui_reset_n_i ? app_rd_data_i : '0;
    assign port_rdata_last_o = ui_reset_n_i && app_rd_data_end_i;
    assign app_cmd_o         = wr_q ? 3'd0 : 3'd1;
    assign app_addr_o        = addr_q;
    assign rd_outstanding_o  = count_q;
    assign rd_err_o          = rd_err_q;

    always_ff @(posedge ui_clk_i or negedge ui_reset_n_i) begin
        if (!ui_reset_n_i) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            gnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            beat_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                rr_q   <= (gnt_idx == pid_w'(num_ports_p - 1)) ? '0 : gnt_idx + pid_w'(1);
                gnt_q  <= gnt_idx;
                wr_q   <= (port_cmd_i[3*gnt_idx +: 3] == 3'd0);
                addr_q <= port_addr_i[gnt_idx*ui_addr_width_p +: ui_addr_width_p];
            end
            if (state_q == CMD && app_rdy_i && wr_q) begin
                beat_q <= '0;
            end else if (beat_acc) begin
                beat_q <= beat_last ? '0 : beat_q + cnt_w'(1);
            end
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                count_q <= count_q + occ_w'(1);
            end else if (pop && !push) begin
                count_q <= count_q - occ_w'(1);
            end
            if (app_rd_data_valid_i && fifo_empty) rd_err_q <= 1'b1;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge ui_clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= gnt_q;
    end

endmodule

// File: tb/tb_bsg_dmc_ui_mport.sv
module tb_bsg_dmc_ui_mport;
    localparam int N  = 4;
    localparam int AW = 28;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int BL = 2;
    localparam int D  = 8;

    logic              ui_clk_i = 1'b0;
    logic              ui_reset_n_i;
    logic [N-1:0]      port_v_i;
    logic [3*N-1:0]    port_cmd_i;
    logic [AW*N-1:0]   port_addr_i;
    logic [N-1:0]      port_ready_o;
    logic [N-1:0]      port_wdata_v_i;
    logic [DW*N-1:0]   port_wdata_i;
    logic [MW*N-1:0]   port_wmask_i;
    logic [N-1:0]      port_wdata_ready_o;
    logic [N-1:0]      port_rdata_v_o;
    logic [DW-1:0]     port_rdata_o;
    logic              port_rdata_last_o;
    logic              app_en_o;
    logic [2:0]        app_cmd_o;
    logic [AW-1:0]     app_addr_o;
    logic              app_rdy_i;
    logic              app_wdf_wren_o;
    logic [DW-1:0]     app_wdf_data_o;
    logic [MW-1:0]     app_wdf_mask_o;
    logic              app_wdf_end_o;
    logic              app_wdf_rdy_i;
    logic              app_rd_data_valid_i;
    logic [DW-1:0]     app_rd_data_i;
    logic              app_rd_data_end_i;
    logic [3:0]        rd_outstanding_o;
    logic              rd_err_o;

    bsg_dmc_ui_mport #(
        .num_ports_p(N), .ui_addr_width_p(AW), .ui_data_width_p(DW),
        .burst_len_p(BL), .rd_fifo_depth_p(D)
    ) dut (
        .ui_clk_i(ui_clk_i), .ui_reset_n_i(ui_reset_n_i),
        .port_v_i(port_v_i), .port_cmd_i(port_cmd_i), .port_addr_i(port_addr_i),
        .port_ready_o(port_ready_o), .port_wdata_v_i(port_wdata_v_i),
        .port_wdata_i(port_wdata_i), .port_wmask_i(port_wmask_i),
        .port_wdata_ready_o(port_wdata_ready_o), .port_rdata_v_o(port_rdata_v_o),
        .port_rdata_o(port_rdata_o), .port_rdata_last_o(port_rdata_last_o),
        .app_en_o(app_en_o), .app_cmd_o(app_cmd_o), .app_addr_o(app_addr_o),
        .app_rdy_i(app_rdy_i), .app_wdf_wren_o(app_wdf_wren_o),
        .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
        .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
        .app_rd_data_end_i(app_rd_data_end_i), .rd_outstanding_o(rd_outstanding_o),
        .rd_err_o(rd_err_o)
    );

    always #5 ui_clk_i = ~ui_clk_i;

    int n_chk  = 0;
    int n_pass = 0;
    int en_hold = 0;
    int gnt_cnt [N];

    // Client-side request and write-beat queues, one ring per port.
    logic [2:0]    rq_cmd  [N][64];
    logic [AW-1:0] rq_addr [N][64];
    int            rq_h [N], rq_t [N];
    logic [DW-1:0] wb_dat  [N][64];
    logic [MW-1:0] wb_msk  [N][64];
    int            wb_h [N], wb_t [N];
    logic [N-1:0]  rdy_seen, wrdy_seen;

    // Scoreboard queues.
    logic [127:0] exp_cmd [$];
    logic [127:0] exp_w   [$];
    logic [127:0] exp_r   [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic fail_now(input string nm, input logic [127:0] act);
        n_chk++;
        $display("FAIL %s: got %0h expected nothing pending", nm, act);
    endtask

    task automatic tick();
        @(posedge ui_clk_i);
        #2;
    endtask

    task automatic add_req(input int p, input logic [2:0] c, input logic [AW-1:0] a);
        rq_cmd[p][rq_t[p] % 64]  = c;
        rq_addr[p][rq_t[p] % 64] = a;
        rq_t[p]++;
    endtask

    task automatic add_wb(input int p, input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
        wb_dat[p][wb_t[p] % 64] = d;
        wb_msk[p][wb_t[p] % 64] = m;
        wb_t[p]++;
        exp_w.push_back({d, m, e});
    endtask

    task automatic wait_q(input string nm);
        int t = 0;
        while ((exp_cmd.size() != 0 || exp_w.size() != 0) && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) fail_now(nm, 128'(exp_cmd.size()));
    endtask

    task automatic wait_outs(input string nm, input int v);
        int t = 0;
        while (rd_outstanding_o != 4'(v) && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) fail_now(nm, 128'(rd_outstanding_o));
    endtask

    task automatic ret_burst(input logic [N-1:0] oh, input logic [DW-1:0] base, input bit rdy_on_last);
        for (int b = 0; b < BL; b++) begin
            app_rd_data_valid_i = 1'b1;
            app_rd_data_i       = base + DW'(b);
            app_rd_data_end_i   = (b == BL - 1);
            if (rdy_on_last && b == BL - 1) app_rdy_i = 1'b1;
            exp_r.push_back({oh, base + DW'(b), (b == BL - 1)});
            tick();
        end
        app_rd_data_valid_i = 1'b0;
        app_rd_data_end_i   = 1'b0;
    endtask

    // Client driver: retire what was accepted at the last edge, present the next entry.
    always @(posedge ui_clk_i) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (rdy_seen[k] && rq_h[k] != rq_t[k]) rq_h[k]++;
            if (wrdy_seen[k] && wb_h[k] != wb_t[k]) wb_h[k]++;
            port_v_i[k]               = (rq_h[k] != rq_t[k]);
            port_cmd_i[3*k +: 3]      = port_v_i[k] ? rq_cmd[k][rq_h[k] % 64] : 3'd0;
            port_addr_i[AW*k +: AW]   = port_v_i[k] ? rq_addr[k][rq_h[k] % 64] : '0;
            port_wdata_v_i[k]         = (wb_h[k] != wb_t[k]);
            port_wdata_i[DW*k +: DW]  = port_wdata_v_i[k] ? wb_dat[k][wb_h[k] % 64] : '0;
            port_wmask_i[MW*k +: MW]  = port_wdata_v_i[k] ? wb_msk[k][wb_h[k] % 64] : '0;
        end
        rdy_seen  = '0;
        wrdy_seen = '0;
    end

    // Monitor: pops and compares whenever the DUT presents a transfer.
    always @(negedge ui_clk_i) begin
        logic [127:0] e;
        rdy_seen  = port_ready_o;
        wrdy_seen = port_wdata_ready_o & port_wdata_v_i;
        for (int k = 0; k < N; k++) if (port_ready_o[k]) gnt_cnt[k]++;
        if (port_ready_o != '0) chk("ready_onehot", 128'($onehot(port_ready_o)), 128'(1));
        if (app_en_o && !app_rdy_i) en_hold++;
        if (app_en_o && app_rdy_i) begin
            if (exp_cmd.size() == 0) fail_now("cmd_unexpected", {app_cmd_o, app_addr_o});
            else begin
                e = exp_cmd.pop_front();
                chk("app_cmd", {app_cmd_o, app_addr_o}, e);
            end
        end
        if (app_wdf_wren_o && app_wdf_rdy_i) begin
            if (exp_w.size() == 0) fail_now("wbeat_unexpected", {app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o});
            else begin
                e = exp_w.pop_front();
                chk("wbeat", {app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o}, e);
            end
        end
        if (app_rd_data_valid_i) begin
            if (exp_r.size() == 0) fail_now("rbeat_unexpected", {port_rdata_v_o, port_rdata_o, port_rdata_last_o});
            else begin
                e = exp_r.pop_front();
                chk("rbeat", {port_rdata_v_o, port_rdata_o, port_rdata_last_o}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int tbl [20] = '{2, 0, 3, 1, 1, 2, 0, 0, 3, 2, 1, 3, 0, 2, 3, 1, 0, 1, 2, 3};
        for (int k = 0; k < N; k++) begin
            rq_h[k] = 0; rq_t[k] = 0; wb_h[k] = 0; wb_t[k] = 0; gnt_cnt[k] = 0;
        end
        rdy_seen = '0; wrdy_seen = '0;
        ui_reset_n_i = 1'b0;
        port_v_i = '0; port_cmd_i = '0; port_addr_i = '0;
        port_wdata_v_i = '0; port_wdata_i = '0; port_wmask_i = '0;
        app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1;
        app_rd_data_valid_i = 1'b0; app_rd_data_i = '0; app_rd_data_end_i = 1'b0;

        // All four ports request READ while still in reset.
        for (int p = 0; p < N; p++) begin
            add_req(p, 3'd1, AW'(28'h0100000 + p * 28'h40));
            exp_cmd.push_back({3'd1, AW'(28'h0100000 + p * 28'h40)});
        end
        repeat (3) tick();
        chk("rst_ready", port_ready_o, 0);
        chk("rst_app_en", app_en_o, 0);
        chk("rst_outstanding", rd_outstanding_o, 0);
        chk("rst_err_wren", {rd_err_o, app_wdf_wren_o, port_rdata_v_o}, 0);
        ui_reset_n_i = 1'b1;
        wait_q("t1_grants");
        chk("t1_outstanding", rd_outstanding_o, 4);
        for (int p = 0; p < N; p++) ret_burst(N'(1 << p), 64'h1000 + 64'(p * 16), 1'b0);
        chk("t1_drained", rd_outstanding_o, 0);

        // Port 2 WRITE with command stall, then toggled write-data ready; port 0 READ waits behind it.
        app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b0; en_hold = 0;
        add_req(2, 3'd0, 28'h0ABC000);
        exp_cmd.push_back({3'd0, 28'h0ABC000});
        add_wb(2, 64'h2222_0000_0000_0001, 8'hF0, 1'b0);
        add_wb(2, 64'h2222_0000_0000_0002, 8'h0F, 1'b1);
        g0 = 0;
        for (int t = 0; t < 50 && en_hold < 5; t++) begin
            tick();
            if (en_hold >= 1 && g0 == 0) begin
                add_req(0, 3'd1, 28'h0000500);
                exp_cmd.push_back({3'd1, 28'h0000500});
                g0 = 1;
            end
        end
        app_rdy_i = 1'b1;
        for (int t = 0; t < 40 && exp_w.size() != 0; t++) begin
            app_wdf_rdy_i = ~app_wdf_rdy_i;
            tick();
        end
        app_wdf_rdy_i = 1'b1;
        chk("t2_en_hold", 128'(en_hold), 5);
        wait_q("t2_done");
        ret_burst(4'b0001, 64'h5000, 1'b0);
        chk("t2_drained", rd_outstanding_o, 0);

        // Fill the read FIFO from port 1; a 9th read must wait, a write still passes.
        g0 = gnt_cnt[1];
        for (int i = 0; i < 9; i++) add_req(1, 3'd1, AW'(28'h0200000 + i * 28'h80));
        for (int i = 0; i < 8; i++) exp_cmd.push_back({3'd1, AW'(28'h0200000 + i * 28'h80)});
        wait_outs("t3_fill", 8);
        repeat (5) tick();
        chk("t3_outstanding_8", rd_outstanding_o, 8);
        chk("t3_no_9th", 128'(gnt_cnt[1] - g0), 8);
        add_req(3, 3'd0, 28'h0333000);
        exp_cmd.push_back({3'd0, 28'h0333000});
        add_wb(3, 64'h3333_0000_0000_0001, 8'hFF, 1'b0);
        add_wb(3, 64'h3333_0000_0000_0002, 8'h81, 1'b1);
        wait_q("t3_write");
        chk("t3_still_no_9th", 128'(gnt_cnt[1] - g0), 8);
        exp_cmd.push_back({3'd1, AW'(28'h0200000 + 8 * 28'h80)});
        ret_burst(4'b0010, 64'h6000, 1'b0);
        chk("t3_outstanding_7", rd_outstanding_o, 7);
        wait_q("t3_9th");
        chk("t3_refill_8", rd_outstanding_o, 8);

        // Push and pop on the same edge.
        ret_burst(4'b0010, 64'h6100, 1'b0);
        app_rdy_i = 1'b0;
        g0 = gnt_cnt[0];
        add_req(0, 3'd1, 28'h0000600);
        exp_cmd.push_back({3'd1, 28'h0000600});
        for (int t = 0; t < 50 && gnt_cnt[0] == g0; t++) tick();
        chk("t4_before", rd_outstanding_o, 7);
        ret_burst(4'b0010, 64'h6200, 1'b1);
        chk("t4_after", rd_outstanding_o, 7);
        for (int i = 0; i < 6; i++) ret_burst(4'b0010, 64'h6300 + 64'(i * 16), 1'b0);
        ret_burst(4'b0001, 64'h6900, 1'b0);
        chk("t4_drained", rd_outstanding_o, 0);

        // Twenty reads in rounds of five; pointers wrap several times.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 5; j++) begin
                add_req(tbl[r*5+j], 3'd1, AW'(28'h0400000 + (r*5+j) * 28'h10));
                exp_cmd.push_back({3'd1, AW'(28'h0400000 + (r*5+j) * 28'h10)});
                wait_q("t5_issue");
            end
            chk("t5_outstanding", rd_outstanding_o, 5);
            for (int j = 0; j < 5; j++) ret_burst(N'(1 << tbl[r*5+j]), 64'h7000 + 64'((r*5+j) * 16), 1'b0);
        end
        chk("t5_drained", rd_outstanding_o, 0);

        // Read beat with nothing outstanding.
        chk("t6_err_before", rd_err_o, 0);
        app_rd_data_valid_i = 1'b1; app_rd_data_i = 64'hDEAD; app_rd_data_end_i = 1'b1;
        exp_r.push_back({4'b0000, 64'hDEAD, 1'b1});
        tick();
        app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0;
        chk("t6_err_set", rd_err_o, 1);
        repeat (5) tick();
        chk("t6_err_sticky", rd_err_o, 1);
        chk("t6_outstanding", rd_outstanding_o, 0);

        // Reset while a write burst sits on its first beat.
        app_wdf_rdy_i = 1'b0;
        add_req(1, 3'd0, 28'h0111000);
        exp_cmd.push_back({3'd0, 28'h0111000});
        add_wb(1, 64'h1111_0000_0000_0001, 8'hAA, 1'b0);
        add_wb(1, 64'h1111_0000_0000_0002, 8'h55, 1'b1);
        for (int t = 0; t < 50 && !app_wdf_wren_o; t++) tick();
        chk("t7_in_wdata", app_wdf_wren_o, 1);
        ui_reset_n_i = 1'b0;
        #1;
        chk("t7_rst_outs", {app_en_o, app_wdf_wren_o, app_wdf_end_o, port_ready_o, port_wdata_ready_o,
                            port_rdata_v_o, rd_outstanding_o, app_addr_o}, 0);
        chk("t7_rst_err", rd_err_o, 0);
        for (int k = 0; k < N; k++) begin
            rq_h[k] = rq_t[k];
            wb_h[k] = wb_t[k];
        end
        exp_w.delete();
        repeat (2) tick();
        ui_reset_n_i = 1'b1;
        app_wdf_rdy_i = 1'b1;
        add_req(2, 3'd1, 28'h0002200);
        add_req(0, 3'd1, 28'h0000200);
        exp_cmd.push_back({3'd1, 28'h0000200});
        exp_cmd.push_back({3'd1, 28'h0002200});
        wait_q("t7_grants");
        chk("t7_outstanding", rd_outstanding_o, 2);
        ret_burst(4'b0001, 64'h8000, 1'b0);
        ret_burst(4'b0100, 64'h8100, 1'b0);
        chk("t7_drained", rd_outstanding_o, 0);

        repeat (3) tick();
        chk("end_cmd_q", 128'(exp_cmd.size()), 0);
        chk("end_w_q", 128'(exp_w.size()), 0);
        chk("end_r_q", 128'(exp_r.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
